// File: rtl/dphy_clk_lane_ctrl.sv
// ============================================================================
//  Module   : dphy_clk_lane_ctrl
//  Sequences the D-PHY clock-lane HS receiver from LP line state and
//  supervises byte-clock liveness.   Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dphy_clk_lane_ctrl #(
    parameter int LP_FILT_CYC  = 3,
    parameter int TERM_EN_CYC  = 4,
    parameter int SETTLE_CYC   = 24,
    parameter int ALIVE_TO_CYC = 64
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic lp_clk_p_i,
    input  logic lp_clk_n_i,
    input  logic byte_clk_toggle_i,
    input  logic err_clr_i,
    output logic hs_term_en_o,
    output logic bufr_clr_o,
    output logic bufr_ce_o,
    output logic hs_clk_active_o,
    output logic ulps_o,
    output logic err_o
);

    localparam int CNT_MAX_A = (TERM_EN_CYC > SETTLE_CYC) ? TERM_EN_CYC : SETTLE_CYC;
    localparam int CNT_MAX   = (CNT_MAX_A > ALIVE_TO_CYC) ? CNT_MAX_A : ALIVE_TO_CYC;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int FILT_W    = $clog2(LP_FILT_CYC + 1);

    localparam logic [CNT_W-1:0]  C_TERM_LAST   = CNT_W'(TERM_EN_CYC - 1);
    localparam logic [CNT_W-1:0]  C_SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]  C_ALIVE_LAST  = CNT_W'(ALIVE_TO_CYC - 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX     = CNT_W'(CNT_MAX);
    localparam logic [FILT_W-1:0] C_FILT_MAX    = FILT_W'(LP_FILT_CYC);

    localparam logic [1:0] LP_00 = 2'b00;
    localparam logic [1:0] LP_01 = 2'b01;
    localparam logic [1:0] LP_10 = 2'b10;
    localparam logic [1:0] LP_11 = 2'b11;

    localparam logic [3:0] S_STOP      = 4'd0;
    localparam logic [3:0] S_HS_RQST   = 4'd1;
    localparam logic [3:0] S_TERM_WT   = 4'd2;
    localparam logic [3:0] S_SETTLE    = 4'd3;
    localparam logic [3:0] S_RELEASE   = 4'd4;
    localparam logic [3:0] S_HS_ACT    = 4'd5;
    localparam logic [3:0] S_ULPS_RQ   = 4'd6;
    localparam logic [3:0] S_ULPS      = 4'd7;
    localparam logic [3:0] S_ULPS_EXIT = 4'd8;
    localparam logic [3:0] S_ERROR     = 4'd9;

    logic [1:0]        r_lp_meta, r_lp_sync, r_lp_cand, r_lp_filt;
    logic [FILT_W-1:0] r_filt_cnt, w_filt_run;
    logic              r_tog_meta, r_tog_sync, r_tog_dly, w_tog_edge;
    logic [3:0]        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic w_term, w_clr, w_ce, w_act, w_ulps, w_err;
    logic r_term, r_clr, r_ce, r_act, r_ulps, r_err;

    // Synchronisers idle at LP-11 so reset does not look like an LP-00 entry.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lp_meta  <= LP_11;
            r_lp_sync  <= LP_11;
            r_tog_meta <= 1'b0;
            r_tog_sync <= 1'b0;
            r_tog_dly  <= 1'b0;
        end else begin
            r_lp_meta  <= {lp_clk_p_i, lp_clk_n_i};
            r_lp_sync  <= r_lp_meta;
            r_tog_meta <= byte_clk_toggle_i;
            r_tog_sync <= r_tog_meta;
            r_tog_dly  <= r_tog_sync;
        end
    end

    assign w_tog_edge = r_tog_sync ^ r_tog_dly;

    // Run length of the current synced code, including the present sample.
    assign w_filt_run = (r_lp_sync != r_lp_cand) ? FILT_W'(1) :
                        (r_filt_cnt == C_FILT_MAX) ? r_filt_cnt :
                        r_filt_cnt + FILT_W'(1);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lp_cand  <= LP_11;
            r_lp_filt  <= LP_11;
            r_filt_cnt <= '0;
        end else begin
            r_lp_cand  <= r_lp_sync;
            r_filt_cnt <= w_filt_run;
            if (w_filt_run == C_FILT_MAX) begin
                r_lp_filt <= r_lp_sync;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_STOP;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        case (r_state)
            S_STOP: begin
                case (r_lp_filt)
                    LP_01:   w_state_nxt = S_HS_RQST;
                    LP_10:   w_state_nxt = S_ULPS_RQ;
                    LP_00:   w_state_nxt = S_ERROR;
                    default: w_state_nxt = S_STOP;
                endcase
            end
            S_HS_RQST: begin
                case (r_lp_filt)
                    LP_00:   w_state_nxt = S_TERM_WT;
                    LP_11:   w_state_nxt = S_STOP;
                    LP_10:   w_state_nxt = S_ERROR;
                    default: w_state_nxt = S_HS_RQST;
                endcase
            end
            S_TERM_WT: begin
                if (r_lp_filt == LP_11)             w_state_nxt = S_STOP;
                else if (r_lp_filt != LP_00)        w_state_nxt = S_ERROR;
                else if (r_cnt == C_TERM_LAST)      w_state_nxt = S_SETTLE;
                else                                w_cnt_nxt   = w_cnt_inc;
            end
            S_SETTLE: begin
                if (r_lp_filt == LP_11)             w_state_nxt = S_STOP;
                else if (r_cnt == C_SETTLE_LAST)    w_state_nxt = S_RELEASE;
                else                                w_cnt_nxt   = w_cnt_inc;
            end
            S_RELEASE: begin
                if (r_lp_filt == LP_11)             w_state_nxt = S_STOP;
                else if (w_tog_edge)                w_state_nxt = S_HS_ACT;
                else if (r_cnt == C_ALIVE_LAST)     w_state_nxt = S_ERROR;
                else                                w_cnt_nxt   = w_cnt_inc;
            end
            S_HS_ACT: begin
                // An LP stop outranks a simultaneous liveness timeout.
                if (r_lp_filt == LP_11)             w_state_nxt = S_STOP;
                else if (w_tog_edge)                w_cnt_nxt   = '0;
                else if (r_cnt == C_ALIVE_LAST)     w_state_nxt = S_ERROR;
                else                                w_cnt_nxt   = w_cnt_inc;
            end
            S_ULPS_RQ: begin
                case (r_lp_filt)
                    LP_00:   w_state_nxt = S_ULPS;
                    LP_11:   w_state_nxt = S_STOP;
                    LP_01:   w_state_nxt = S_ERROR;
                    default: w_state_nxt = S_ULPS_RQ;
                endcase
            end
            S_ULPS: begin
                case (r_lp_filt)
                    LP_00:   w_state_nxt = S_ULPS;
                    LP_10:   w_state_nxt = S_ULPS_EXIT;
                    default: w_state_nxt = S_ERROR;
                endcase
            end
            S_ULPS_EXIT: begin
                case (r_lp_filt)
                    LP_11:   w_state_nxt = S_STOP;
                    LP_00:   w_state_nxt = S_ERROR;
                    default: w_state_nxt = S_ULPS_EXIT;
                endcase
            end
            S_ERROR: begin
                if (err_clr_i && (r_lp_filt == LP_11)) w_state_nxt = S_STOP;
            end
            default: w_state_nxt = S_STOP;
        endcase
    end

    always_comb begin
        w_term = (r_state == S_SETTLE) || (r_state == S_RELEASE) || (r_state == S_HS_ACT);
        w_ce   = (r_state == S_RELEASE) || (r_state == S_HS_ACT);
        w_clr  = !w_ce;
        w_act  = (r_state == S_HS_ACT);
        w_ulps = (r_state == S_ULPS);
        w_err  = (r_state == S_ERROR);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_term <= 1'b0;
            r_clr  <= 1'b1;
            r_ce   <= 1'b0;
            r_act  <= 1'b0;
            r_ulps <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_term <= w_term;
            r_clr  <= w_clr;
            r_ce   <= w_ce;
            r_act  <= w_act;
            r_ulps <= w_ulps;
            r_err  <= w_err;
        end
    end

    assign hs_term_en_o    = r_term;
    assign bufr_clr_o      = r_clr;
    assign bufr_ce_o       = r_ce;
    assign hs_clk_active_o = r_act;
    assign ulps_o          = r_ulps;
    assign err_o           = r_err;

endmodule

`default_nettype wire
